// File: rtl/puf_resp_streamer.sv
// puf_resp_streamer
//   Reads one word from the PUF challenge/response ROM and streams it out as
//   bytes, most significant byte first. An XOR checksum byte can be appended
//   after the data bytes.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   chal_valid/chal     challenge offered by the host command path
//   chal_ready          high only while idle (challenges are not buffered)
//   rom_addr            registered ROM address (last accepted challenge)
//   rom_data            combinational ROM word for rom_addr
//   out_valid/out_byte  byte stream toward the host, held while stalled
//   out_last            marks the final byte of a response
//   out_ready           downstream accepts out_byte
//   busy                high whenever the block is not idle
module puf_resp_streamer #(
  parameter int ADDR_SZ     = 8,
  parameter int DATA_SZ     = 264,
  parameter int APPEND_CSUM = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               chal_valid,
  input  logic [ADDR_SZ-1:0] chal,
  output logic               chal_ready,
  output logic [ADDR_SZ-1:0] rom_addr,
  input  logic [DATA_SZ-1:0] rom_data,
  output logic               out_valid,
  output logic [7:0]         out_byte,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy
);

  localparam int NB = DATA_SZ / 8;
  localparam logic [5:0] LAST_IDX = 6'(NB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    CSUM  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [DATA_SZ-1:0] shreg_q, shreg_d;
  logic [5:0]         idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;

  logic last_data;
  assign last_data = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    chal_ready = 1'b0;
    out_valid  = 1'b0;
    out_byte   = 8'h00;
    out_last   = 1'b0;
    case (state_q)
      IDLE: begin
        chal_ready = 1'b1;
        if (chal_valid) begin
          addr_d  = chal;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // rom_addr has been stable for a full cycle, so the ROM word is settled.
        shreg_d = rom_data;
        idx_d   = '0;
        csum_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_byte  = shreg_q[DATA_SZ-1 -: 8];
        out_last  = (APPEND_CSUM == 0) && last_data;
        if (out_ready) begin
          shreg_d = shreg_q << 8;
          csum_d  = csum_q ^ shreg_q[DATA_SZ-1 -: 8];
          if (last_data) begin
            state_d = (APPEND_CSUM != 0) ? CSUM : IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      CSUM: begin
        out_valid = 1'b1;
        out_byte  = csum_q;
        out_last  = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr = addr_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_puf_resp_streamer.sv
// Testbench for puf_resp_streamer: a ROM model feeds two instances (with and
// without checksum byte); a scoreboard queue holds the expected bytes of each
// accepted challenge and a negedge monitor compares every handshaked byte.
module tb_puf_resp_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic         chal_valid;
  logic [7:0]   chal;
  logic         chal_ready;
  logic [7:0]   rom_addr;
  logic [263:0] rom_data;
  logic         out_valid;
  logic [7:0]   out_byte;
  logic         out_last;
  logic         out_ready = 1'b1;
  logic         busy;

  logic         c0_valid;
  logic [7:0]   c0_chal;
  logic         c0_ready;
  logic [7:0]   c0_addr;
  logic [263:0] c0_data;
  logic         c0_out_valid;
  logic [7:0]   c0_out_byte;
  logic         c0_out_last;
  logic         c0_out_ready;
  logic         c0_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit ready_mode = 1'b0;

  logic [8:0] exp_q[$];
  logic [7:0] cur_stream[40];
  logic [7:0] done_stream[40];
  int   stream_cnt = 0;
  int   n_done = 0;
  int   n_accept = 0;
  int   accept_cyc = 0;
  int   accept_cyc_prev = 0;
  logic [7:0] cur_addr = 8'h00;
  bit   stall_prev = 1'b0;
  logic [7:0] prev_byte;
  logic       prev_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Address 0x13 holds a programmed response; every other address reads the
  // default map.
  function automatic logic [7:0] rom_byte(input logic [7:0] a, input int k);
    if (a == 8'h13) begin
      case (k)
        0: return 8'h12;
        1: return 8'hb9;
        2: return 8'h3c;
        3: return 8'hca;
        32: return 8'haf;
        default: return 8'(k * 29) ^ 8'h47;
      endcase
    end else begin
      case (k)
        0: return 8'h12;
        1: return 8'hbe;
        2: return 8'h4a;
        32: return 8'h0f;
        default: return 8'(k * 11) ^ 8'hc3;
      endcase
    end
  endfunction

  function automatic logic [263:0] rom_word(input logic [7:0] a);
    logic [263:0] w;
    w = '0;
    for (int k = 0; k < 33; k++) w[263 - 8*k -: 8] = rom_byte(a, k);
    return w;
  endfunction

  always_comb rom_data = rom_word(rom_addr);
  always_comb c0_data  = rom_word(c0_addr);

  puf_resp_streamer #(.ADDR_SZ(8), .DATA_SZ(264), .APPEND_CSUM(1)) dut (
    .clk(clk), .rst(rst), .chal_valid(chal_valid), .chal(chal),
    .chal_ready(chal_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  puf_resp_streamer #(.ADDR_SZ(8), .DATA_SZ(264), .APPEND_CSUM(0)) dut0 (
    .clk(clk), .rst(rst), .chal_valid(c0_valid), .chal(c0_chal),
    .chal_ready(c0_ready), .rom_addr(c0_addr), .rom_data(c0_data),
    .out_valid(c0_out_valid), .out_byte(c0_out_byte), .out_last(c0_out_last),
    .out_ready(c0_out_ready), .busy(c0_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Random backpressure when ready_mode is set; inputs change just after posedge.
  always @(posedge clk) begin
    #1;
    out_ready = ready_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: sampled at negedge, so values match what the next posedge sees.
  always @(negedge clk) begin
    logic [8:0] e;
    logic [7:0] cs;
    if (rst) begin
      exp_q.delete();
      stream_cnt = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_byte", 32'(out_byte), 32'(prev_byte));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      stall_prev = out_valid && !out_ready;
      prev_byte  = out_byte;
      prev_last  = out_last;
      if (busy) check("rom_addr_hold", 32'(rom_addr), 32'(cur_addr));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'(out_byte), 32'(e[7:0]));
          check("last", 32'(out_last), 32'(e[8]));
        end
        $display("byte[%0d] = 0x%02h last=%0b", stream_cnt, out_byte, out_last);
        if (stream_cnt < 40) cur_stream[stream_cnt] = out_byte;
        stream_cnt++;
        if (out_last) begin
          done_stream = cur_stream;
          n_done++;
          stream_cnt = 0;
        end
      end
      if (chal_valid && chal_ready) begin
        cs = 8'h00;
        for (int k = 0; k < 33; k++) begin
          exp_q.push_back({1'b0, rom_byte(chal, k)});
          cs ^= rom_byte(chal, k);
        end
        exp_q.push_back({1'b1, cs});
        cur_addr        = chal;
        accept_cyc_prev = accept_cyc;
        accept_cyc      = cyc;
        n_accept++;
        $display("challenge 0x%02h accepted at cycle %0d", chal, cyc);
      end
    end
  end

  task automatic check_reset_outputs(input string sfx);
    check({"rst_chal_ready", sfx}, 32'(chal_ready), 32'd1);
    check({"rst_rom_addr", sfx}, 32'(rom_addr), 32'd0);
    check({"rst_out_valid", sfx}, 32'(out_valid), 32'd0);
    check({"rst_out_byte", sfx}, 32'(out_byte), 32'd0);
    check({"rst_out_last", sfx}, 32'(out_last), 32'd0);
    check({"rst_busy", sfx}, 32'(busy), 32'd0);
  endtask

  task automatic wait_accept(input int start);
    bit ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (n_accept != start) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'(n_accept), 32'(start + 1));
  endtask

  task automatic send_chal(input logic [7:0] c);
    int start = n_accept;
    @(posedge clk); #1;
    chal = c;
    chal_valid = 1'b1;
    wait_accept(start);
    @(posedge clk); #1;
    chal_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    bit ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (n_done >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("done_timeout", 32'(n_done), 32'(n));
  endtask

  task automatic wait_bytes(input int n);
    bit ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (stream_cnt >= n) begin ok = 1'b1; break; end
    end
    if (!ok) check("bytes_timeout", 32'(stream_cnt), 32'(n));
  endtask

  initial begin
    int done_before;
    int n0;
    logic [7:0] b32;
    rst = 1'b1;
    chal_valid = 1'b0;
    chal = 8'h00;
    c0_valid = 1'b0;
    c0_chal = 8'h00;
    c0_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("");

    // Challenge 0x13 held valid: latency, back-to-back re-acceptance, occupancy.
    @(posedge clk); #1;
    chal = 8'h13;
    chal_valid = 1'b1;
    @(negedge clk);
    check("idle_chal_ready", 32'(chal_ready), 32'd1);
    @(negedge clk);
    check("fetch_chal_ready", 32'(chal_ready), 32'd0);
    check("fetch_busy", 32'(busy), 32'd1);
    check("fetch_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_out_byte", 32'(out_byte), 32'h12);
    wait_done(1);
    check("s13_b1", 32'(done_stream[1]), 32'hb9);
    check("s13_b2", 32'(done_stream[2]), 32'h3c);
    check("s13_b3", 32'(done_stream[3]), 32'hca);
    check("s13_b32", 32'(done_stream[32]), 32'haf);
    if (n_accept < 2) wait_accept(1);
    @(posedge clk); #1;
    chal_valid = 1'b0;
    check("occupancy", 32'(accept_cyc - accept_cyc_prev), 32'd36);
    wait_done(2);

    // Default-map address 0x00.
    send_chal(8'h00);
    wait_done(3);
    check("s00_b0", 32'(done_stream[0]), 32'h12);
    check("s00_b1", 32'(done_stream[1]), 32'hbe);
    check("s00_b2", 32'(done_stream[2]), 32'h4a);
    check("s00_b32", 32'(done_stream[32]), 32'h0f);

    // 0x95 under random backpressure, with 0x2A offered mid-stream.
    ready_mode = 1'b1;
    send_chal(8'h95);
    done_before = n_done;
    wait_bytes(5);
    @(posedge clk); #1;
    chal = 8'h2A;
    chal_valid = 1'b1;
    @(negedge clk);
    check("busy_chal_ready", 32'(chal_ready), 32'd0);
    wait_accept(n_accept);
    check("accept_after_last", 32'(n_done), 32'(done_before + 1));
    @(posedge clk); #1;
    chal_valid = 1'b0;
    wait_done(done_before + 2);
    check("s2a_b0", 32'(done_stream[0]), 32'h12);
    check("s2a_b1", 32'(done_stream[1]), 32'hbe);
    ready_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a stream, then a fresh stream.
    send_chal(8'h13);
    wait_bytes(10);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    done_before = n_done;
    send_chal(8'h13);
    wait_done(done_before + 1);
    check("after_rst_b0", 32'(done_stream[0]), 32'h12);
    check("after_rst_b32", 32'(done_stream[32]), 32'haf);

    // Instance without checksum byte.
    @(posedge clk); #1;
    c0_chal = 8'h13;
    c0_valid = 1'b1;
    @(posedge clk); #1;
    c0_valid = 1'b0;
    n0 = 0;
    b32 = 8'h00;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (c0_out_valid && c0_out_ready) begin
        check("c0_byte", 32'(c0_out_byte), 32'(rom_byte(8'h13, n0)));
        check("c0_last", 32'(c0_out_last), 32'(n0 == 32));
        $display("c0 byte[%0d] = 0x%02h last=%0b", n0, c0_out_byte, c0_out_last);
        if (n0 == 32) b32 = c0_out_byte;
        n0++;
        if (c0_out_last) break;
      end
    end
    check("c0_count", 32'(n0), 32'd33);
    check("c0_b32", 32'(b32), 32'haf);
    @(negedge clk);
    check("c0_busy_after", 32'(c0_busy), 32'd0);
    check("c0_valid_after", 32'(c0_out_valid), 32'd0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/puf_resp_streamer.md
# puf_resp_streamer

Reader and serializer for the PUF challenge/response ROM. It accepts an 8-bit challenge over a valid/ready handshake and drives the challenge onto the ROM address bus. It captures the 264-bit response word, then streams it out as 33 bytes, MSB first, on a byte-wide valid/ready interface. An optional XOR checksum byte follows the data. The block sits between the challenge source (UART/host command path) and the ROM, so the host can read the stored response.

## Interface
- ADDR_SZ, 8, challenge / ROM address width
- DATA_SZ, 264, ROM word width; must be a multiple of 8
- APPEND_CSUM, 1, when 1 a 34th byte (XOR of all data bytes) follows the data
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- chal_valid  in  1  challenge present
- chal  in  ADDR_SZ  challenge value
- chal_ready  out  1  block can accept a challenge
- rom_addr  out  ADDR_SZ  registered address to the combinational ROM
- rom_data  in  DATA_SZ  ROM word; valid in the same cycle as rom_addr
- out_valid  out  1  out_byte is valid
- out_byte  out  8  stream byte
- out_last  out  1  marks the final byte of a response
- out_ready  in  1  downstream accepts out_byte
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: chal_ready=1. On chal_valid, latch chal into rom_addr and go to FETCH.
  - FETCH: lasts exactly one cycle. Load rom_data into the 264-bit shift register, clear the byte index and checksum, and go to SEND.
  - SEND: out_valid=1 and out_byte = shreg[DATA_SZ-1 -: 8].
    - On each out_valid && out_ready: shift shreg left by 8, XOR the sent byte into csum, and increment idx.
    - After data byte NB-1 (NB = DATA_SZ/8 = 33): go to CSUM if APPEND_CSUM=1, otherwise go to IDLE.
  - CSUM: out_valid=1 and out_byte=csum. On handshake, go to IDLE.
- out_last=1 only on the final byte of the response: byte 33 (CSUM) if APPEND_CSUM=1, else byte NB-1.
- chal_ready=0 in every state except IDLE. Challenges offered while busy are not accepted or buffered; the source must hold them.
- out_byte, out_valid and out_last are held stable while out_valid && !out_ready.
- rom_addr holds the last accepted challenge until the next acceptance.
- Widths and counters:
  - idx is 6 bits and counts 0..NB-1 with no wrap.
  - csum is 8 bits, pure XOR, reset to 0 at FETCH.
- Reset while in any state: all registers clear asynchronously and the state returns to IDLE. Any partial stream is abandoned with no out_last; the next response starts fresh.

## Timing
- Reset values: chal_ready=1, rom_addr=0, out_valid=0, out_byte=0, out_last=0, busy=0.
- Challenge accepted at edge E0. FETCH is cycle E0..E1 and rom_data is sampled at E1. The first byte is valid after E1: 2-cycle latency from acceptance to first out_valid.
- With out_ready held high: one byte per cycle, so 33 data cycles plus 1 CSUM cycle. chal_ready returns to 1 in the cycle after the last handshake.
- Total occupancy with out_ready=1 and APPEND_CSUM=1: 36 cycles from acceptance to the next possible acceptance.
- Back-to-back: chal_valid held high continuously is accepted again in the first IDLE cycle, with no gap cycle beyond IDLE.
- Only the registered rom_addr drives the ROM, so the ROM input path has no combinational path from chal.

## Test plan
- Reset, then hold chal=8'h13 with chal_valid=1 and out_ready=1.
  - chal_ready drops after one edge; first out_valid appears 2 cycles later.
  - Bytes are 0x12, 0xb9, 0x3c, 0xca, … with byte 32 = 0xaf.
  - Byte 33 equals the XOR of the 33 data bytes, with out_last=1 only there.
- chal=8'h00 (a default-map address): bytes are 0x12, 0xbe, 0x4a, … with byte 32 = 0x0f. rom_addr stays 8'h00 throughout.
- chal=8'h95 with out_ready toggling randomly: the byte sequence is identical to the out_ready=1 run, and out_byte/out_last stay stable on every stalled cycle.
- Offer chal=8'h2A while busy, during SEND: chal_ready=0 and it is not accepted. It is accepted in the first IDLE cycle after out_last completes, and its stream then begins 0x12, 0xbe.
- Assert rst mid-SEND at byte 10: all outputs return to reset values immediately. A new challenge 8'h13 then streams from byte 0 (0x12) with the correct checksum.
- APPEND_CSUM=0 build, chal=8'h13: exactly 33 bytes, out_last on byte 32 (0xaf), and busy low the cycle after.
